// File: rtl/data_mem_ws.sv
// data_mem_ws: single-port data memory with a fixed number of wait states.
// One access at a time: IDLE accepts a request, WAIT burns the configured
// wait cycles, DONE pulses ready with the load result or misalign flag.
// Byte/halfword/word stores and loads, little-endian, with sign/zero extension.
module data_mem_ws #(
   parameter int DEPTH = 256,
   parameter int WAIT  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        misalign,
   output logic        busy
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [3:0] WAIT_CNT = 4'(WAIT);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;

   // Request fields captured at acceptance
   logic        lat_we;
   logic [1:0]  lat_size;
   logic        lat_sx;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;

   // Fields of the access in progress (live inputs while still in IDLE)
   logic        acc_we;
   logic [1:0]  acc_size;
   logic        acc_sx;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;

   logic [AW-1:0] idx;
   logic          accept;
   logic          enter_done;
   logic          mis;
   logic [31:0]   word_rd;
   logic [31:0]   lane_shift;
   logic [15:0]   half_rd;
   logic [31:0]   load_val;
   logic [3:0]    be;
   logic [31:0]   wd_rep;
   logic          unused_addr;

   // NOTE: memory has no reset; contents survive rst_n and start at zero from the declaration.
   logic [31:0] mem [DEPTH] = '{default: '0};

   // Select which copy of the request fields describes the current access
   always_comb begin
      if (state == ST_IDLE) begin
         acc_we    = we;
         acc_size  = size;
         acc_sx    = sign_ext;
         acc_addr  = addr;
         acc_wdata = wdata;
      end else begin
         acc_we    = lat_we;
         acc_size  = lat_size;
         acc_sx    = lat_sx;
         acc_addr  = lat_addr;
         acc_wdata = lat_wdata;
      end
   end

   assign idx         = acc_addr[AW+1:2];
   assign unused_addr = ^acc_addr[31:AW+2];
   assign accept      = (state == ST_IDLE) && req;
   assign enter_done  = (accept && (WAIT == 0)) || ((state == ST_WAIT) && (cnt == 4'd1));
   assign mis         = ((acc_size == 2'b01) && acc_addr[0]) ||
                        (acc_size[1] && (acc_addr[1:0] != 2'b00));
   assign ready       = (state == ST_DONE);
   assign busy        = (state != ST_IDLE);

   // Next-state and wait-counter logic
   always_comb begin
      // NOTE: defaults first so every path assigns every output; no latches inferred.
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         ST_IDLE: begin
            if (req) begin
               if (WAIT == 0) begin
                  state_nx = ST_DONE;
               end else begin
                  state_nx = ST_WAIT;
                  cnt_nx   = WAIT_CNT;
               end
            end
         end
         ST_WAIT: begin
            cnt_nx = cnt - 4'd1;
            if (cnt == 4'd1) state_nx = ST_DONE;
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // State register and wait counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         state <= ST_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Capture the request fields on acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_we    <= 1'b0;
         lat_size  <= 2'b00;
         lat_sx    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (accept) begin
         lat_we    <= we;
         lat_size  <= size;
         lat_sx    <= sign_ext;
         lat_addr  <= addr;
         lat_wdata <= wdata;
      end
   end

   // Extract the addressed lane(s) and extend to 32 bits
   always_comb begin
      word_rd    = mem[idx];
      lane_shift = word_rd >> {acc_addr[1:0], 3'b000};
      half_rd    = acc_addr[1] ? word_rd[31:16] : word_rd[15:0];
      load_val   = word_rd;
      case (acc_size)
         2'b00:   load_val = acc_sx ? {{24{lane_shift[7]}}, lane_shift[7:0]}
                                    : {24'h0, lane_shift[7:0]};
         2'b01:   load_val = acc_sx ? {{16{half_rd[15]}}, half_rd}
                                    : {16'h0, half_rd};
         default: load_val = word_rd;
      endcase
   end

   // Byte enables and lane-replicated store data
   always_comb begin
      be     = 4'b0000;
      wd_rep = acc_wdata;
      case (acc_size)
         2'b00: begin
            be[acc_addr[1:0]] = 1'b1;
            wd_rep            = {4{acc_wdata[7:0]}};
         end
         2'b01: begin
            be     = acc_addr[1] ? 4'b1100 : 4'b0011;
            wd_rep = {2{acc_wdata[15:0]}};
         end
         default: be = 4'b1111;
      endcase
   end

   // Commit an aligned store on the edge entering DONE; reset blocks the write
   always_ff @(posedge clk) begin
      if (rst_n && enter_done && acc_we && !mis) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wd_rep[8*b +: 8];
         end
      end
   end

   // Load result and misalign flag, updated on the edge entering DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata    <= '0;
         misalign <= 1'b0;
      end else begin
         if (accept) misalign <= 1'b0;
         if (enter_done) begin
            misalign <= mis;
            if (mis)          rdata <= '0;
            else if (!acc_we) rdata <= load_val;
         end
      end
   end

endmodule

// File: doc/data_mem_ws.md
DATA_MEM_WS -- requirements
Module: data_mem_ws

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words; power of two, 4..65536.
REQ-002 SHALL have parameter WAIT, default 1, added wait cycles per access; range 0..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port req  input  1  access request; sampled only in IDLE.
REQ-006 SHALL have port we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port size  input  2  00 byte, 01 halfword, 10 word; 11 treated as word.
REQ-008 SHALL have port sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-009 SHALL have port addr  input  32  byte address.
REQ-010 SHALL have port wdata  input  32  store data; bytes/halves taken from the low bits.
REQ-011 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rdata  output  32  load result; valid while ready = 1, held otherwise.
REQ-013 SHALL have port misalign  output  1  valid with ready: access rejected as misaligned.
REQ-014 SHALL have port busy  output  1  high from the cycle after req acceptance through the ready cycle.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and DONE.
REQ-016 SHALL, in IDLE with req = 1, latch we, size, sign_ext, addr and wdata.
  - Next state: WAIT when WAIT > 0, else DONE.
REQ-017 SHALL hold WAIT for exactly WAIT cycles, using a down-counter loaded on acceptance, then move to DONE.
REQ-018 SHALL drive ready = 1 for exactly one cycle in DONE, then return to IDLE.
  - Latency: req-sampling edge to ready high = WAIT+1 cycles.
  - Minimum request spacing: WAIT+2 cycles.
REQ-019 SHALL ignore req while in WAIT or DONE; no queuing.
REQ-020 SHALL form the word index from addr[log2(DEPTH)+1:2].
  - Upper address bits are ignored, so addresses wrap modulo 4*DEPTH.
REQ-021 SHALL treat an access as misaligned when any of these hold:
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 00.
REQ-022 SHALL store little-endian:
  - byte writes lane addr[1:0];
  - halfword writes lanes {addr[1],0} and {addr[1],1};
  - word writes all four lanes;
  - other lanes are unchanged.
REQ-023 SHALL commit a store on the edge entering DONE; the store SHALL be suppressed if misaligned.
REQ-024 SHALL capture a load into rdata on the edge entering DONE, from the addressed lane(s).
  - Result is extended to 32 bits per sign_ext.
  - Word loads ignore sign_ext.
REQ-025 SHALL set misalign = 1 and rdata = 0 on a misaligned access; the memory SHALL be unchanged.
REQ-026 SHALL keep rdata unchanged by stores; misalign SHALL be cleared on the next accepted access.
REQ-027 SHALL zero memory contents at elaboration.

Reset
REQ-028 SHALL, while rst_n = 0, force:
  - state IDLE, wait counter 0;
  - ready = 0, busy = 0, misalign = 0, rdata = 0.
REQ-029 SHALL NOT clear memory contents on reset.
REQ-030 SHALL abort an in-flight access when reset is asserted before the DONE edge; no store is committed.
REQ-031 SHALL accept req on the first rising edge after rst_n deasserts.

Verification
REQ-032 Word store/load, WAIT=1: store 0xDEADBEEF @0x10, then load word @0x10 -> ready 2 cycles after each req; rdata = 0xDEADBEEF, misalign = 0.
REQ-033 Byte lanes: after REQ-032, store byte 0x80 @0x12, then:
  - load word @0x10 -> 0xDE80BEEF;
  - load byte @0x12, sign_ext = 1 -> 0xFFFFFF80;
  - load byte @0x12, sign_ext = 0 -> 0x00000080.
REQ-034 Misalignment: store word 0x11111111 @0x21 -> ready with misalign = 1, rdata = 0; then load word @0x20 -> 0x00000000.
REQ-035 Wrap, DEPTH=256: store word 0x12345678 @0x400, then load word @0x0 -> 0x12345678.
REQ-036 Reset mid-access, WAIT=3: store 0xCAFEF00D @0x8, assert rst_n = 0 one cycle after acceptance.
  - Expect: ready never pulses, busy = 0 immediately.
  - After release, load @0x8 -> prior value (0x00000000).
REQ-037 Busy ignore, WAIT=2: hold req = 1 for 6 cycles -> exactly two accesses complete, ready pulses 4 cycles apart.
